// File: rtl/data_memory_dumper.sv
// Read-side dump master: walks data memory addresses 0..DUMP_DEPTH-1 and
// streams each word MSB byte first to the UART transmitter, one byte per tx_done.
module data_memory_dumper #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 11,
  parameter int DUMP_DEPTH    = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_write,
  input  logic [RAM_WIDTH-1:0]     mem_rdata,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_done
);

  localparam int NUM_BYTES = RAM_WIDTH / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [IDX_W-1:0]         LAST_BYTE = IDX_W'(NUM_BYTES - 1);
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(DUMP_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
  logic [RAM_WIDTH-1:0]     word_q, word_d;
  logic [7:0]               tx_data_q, tx_data_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // NOTE: every combinational output gets a default first; a path that leaves
  // a variable unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          if (byte_idx_q != LAST_BYTE)      state_d = SEND;
          else if (mem_addr_q != LAST_ADDR) state_d = READ;
          else                              state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The word is kept left-aligned and shifted up one byte per transmitted
  // byte, so the outgoing byte is always the top slice.
  always_comb begin
    mem_addr_d = mem_addr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mem_addr_d = '0;
          byte_idx_d = '0;
        end
      end
      CAPTURE: begin
        word_d    = mem_rdata;
        tx_data_d = mem_rdata[RAM_WIDTH-1 -: 8];
      end
      WAIT_TX: begin
        if (tx_done) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            word_d     = word_q << 8;
            tx_data_d  = word_d[RAM_WIDTH-1 -: 8];
          end else if (mem_addr_q != LAST_ADDR) begin
            mem_addr_d = mem_addr_q + RAM_ADDR_BITS'(1);
            byte_idx_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      IDLE:    ;
      SEND:    begin busy = 1'b1; tx_start = 1'b1; end
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: busy = 1'b1;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign tx_data   = tx_data_q;
  // The processor is halted during a dump; this master only ever reads.
  assign mem_write = 1'b0;

endmodule

// File: tb/tb_data_memory_dumper.sv
// Directed bench for data_memory_dumper: default 16-bit/128-word instance
// plus a 32-bit/4-word instance, each with a registered memory and TX model.
module tb_data_memory_dumper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- instance A: defaults ----------------
  logic        start_a, busy_a, done_a, mem_write_a, tx_start_a, tx_done_a;
  logic [10:0] mem_addr_a;
  logic [15:0] rdata_a;
  logic [7:0]  tx_data_a;
  logic [15:0] mem_a [2048];
  logic        force_done_a = 1'b0;
  logic        model_done_a = 1'b0;
  int          lat_a = 10;
  int          cnt_a = 0;
  logic [7:0]  bytes_a [$];
  int          done_cnt_a = 0;
  bit          wr_seen_a = 1'b0;
  bit          addr_over_a = 1'b0;

  data_memory_dumper dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_addr(mem_addr_a), .mem_write(mem_write_a), .mem_rdata(rdata_a),
    .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_done(tx_done_a)
  );

  assign tx_done_a = model_done_a | force_done_a;
  always @(posedge clk) rdata_a <= mem_a[mem_addr_a];

  always @(negedge clk) begin
    model_done_a <= (cnt_a == 1);
    if (tx_start_a)      cnt_a <= lat_a;
    else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    if (tx_start_a) bytes_a.push_back(tx_data_a);
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (mem_write_a !== 1'b0) wr_seen_a <= 1'b1;
    if (mem_addr_a > 11'd127) addr_over_a <= 1'b1;
  end

  // ---------------- instance B: 32-bit words, 4 deep ----------------
  logic        start_b, busy_b, done_b, mem_write_b, tx_start_b, tx_done_b;
  logic [10:0] mem_addr_b;
  logic [31:0] rdata_b;
  logic [7:0]  tx_data_b;
  logic [31:0] mem_b [2048];
  logic        model_done_b = 1'b0;
  int          cnt_b = 0;
  logic [7:0]  bytes_b [$];
  int          done_cnt_b = 0;
  bit          addr_over_b = 1'b0;

  data_memory_dumper #(.RAM_WIDTH(32), .RAM_ADDR_BITS(11), .DUMP_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_addr(mem_addr_b), .mem_write(mem_write_b), .mem_rdata(rdata_b),
    .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_done(tx_done_b)
  );

  assign tx_done_b = model_done_b;
  always @(posedge clk) rdata_b <= mem_b[mem_addr_b];

  always @(negedge clk) begin
    model_done_b <= (cnt_b == 1);
    if (tx_start_b)      cnt_b <= 2;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    if (tx_start_b) bytes_b.push_back(tx_data_b);
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (mem_write_b !== 1'b0 || mem_addr_b > 11'd3) addr_over_b <= 1'b1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input bit sel_b, input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      step();
      if ((sel_b ? done_b : done_a) === 1'b1) break;
    end
    check(sel_b ? "done_b_seen" : "done_a_seen", {31'd0, sel_b ? done_b : done_a}, 32'd1);
  endtask

  task automatic wait_bytes_a(input int target, input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (bytes_a.size() >= target) break;
      step();
    end
    check("bytes_a_reached", bytes_a.size(), target);
  endtask

  task automatic wait_tx_start_a(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      step();
      if (tx_start_a === 1'b1) break;
    end
    check("tx_start_a_seen", {31'd0, tx_start_a}, 32'd1);
  endtask

  // 256 bytes A5,00,A5,01,...,A5,7F starting at queue index b0
  task automatic check_full_dump_a(input string tag, input int b0);
    check({tag, "_count"}, bytes_a.size() - b0, 256);
    for (int i = 0; i < 256 && (b0 + i) < bytes_a.size(); i++)
      check({tag, "_byte"}, {24'd0, bytes_a[b0+i]}, i[0] ? i >> 1 : 32'hA5);
  endtask

  logic [7:0] exp_b [16] = '{8'h01, 8'h02, 8'h03, 8'h04,
                             8'h01, 8'h02, 8'h03, 8'h14,
                             8'h01, 8'h02, 8'h03, 8'h24,
                             8'h01, 8'h02, 8'h03, 8'h34};

  int b0, b1, d0;

  initial begin
    for (int k = 0; k < 2048; k++) begin
      mem_a[k] = 16'hA500 + 16'(k);
      mem_b[k] = 32'h01020304 + 32'(k) * 32'h10;
    end

    // Reset held with start asserted and random tx_done: everything stays 0.
    rst_n = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      force_done_a = 1'($urandom_range(0, 1));
      step();
      check("reset_outs_a", {9'd0, busy_a, done_a, tx_start_a, mem_write_a, tx_data_a, mem_addr_a}, 32'd0);
      check("reset_outs_b", {9'd0, busy_b, done_b, tx_start_b, mem_write_b, tx_data_b, mem_addr_b}, 32'd0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    force_done_a = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_after_reset", {30'd0, busy_a, tx_start_a}, 32'd0);

    // Latency with a 1-cycle TX: start held in cycle s, tx_start at s+3,
    // next byte 1 cycle after tx_done, next word 3 cycles after tx_done.
    lat_a = 1;
    b0 = bytes_a.size();
    d0 = done_cnt_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("lat_read_busy", {31'd0, busy_a}, 32'd1);
    check("lat_read_addr", {21'd0, mem_addr_a}, 32'd0);
    step();
    check("lat_capture_no_tx", {31'd0, tx_start_a}, 32'd0);
    step();
    check("lat_first_tx_start", {23'd0, tx_start_a, tx_data_a}, 32'h1A5);
    step();
    check("lat_first_done", {30'd0, tx_done_a, tx_start_a}, 32'b10);
    step();
    check("lat_second_tx_start", {23'd0, tx_start_a, tx_data_a}, 32'h100);
    step();
    check("lat_second_done", {30'd0, tx_done_a, tx_start_a}, 32'b10);
    step();
    check("lat_word_read", {20'd0, tx_start_a, mem_addr_a}, 32'h001);
    step();
    check("lat_word_capture", {31'd0, tx_start_a}, 32'd0);
    step();
    check("lat_word_tx_start", {23'd0, tx_start_a, tx_data_a}, 32'h1A5);
    wait_done(1'b0, 3000);
    check("lat_done_busy", {31'd0, busy_a}, 32'd1);
    step();
    check("lat_busy_falls", {30'd0, busy_a, done_a}, 32'd0);
    check_full_dump_a("lat_dump", b0);
    check("lat_done_count", done_cnt_a - d0, 1);

    // Full dump with a 10-cycle TX.
    lat_a = 10;
    b0 = bytes_a.size();
    d0 = done_cnt_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_done(1'b0, 8000);
    repeat (2) step();
    check_full_dump_a("full_dump", b0);
    check("full_done_count", done_cnt_a - d0, 1);

    // Ignored events: tx_done in IDLE and SEND, start in WAIT_TX and DONE.
    b0 = bytes_a.size();
    d0 = done_cnt_a;
    force_done_a = 1'b1;
    step();
    force_done_a = 1'b0;
    step();
    check("idle_tx_done_ignored", {31'd0, busy_a}, 32'd0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_tx_start_a(10);
    force_done_a = 1'b1;
    step();
    force_done_a = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("send_tx_done_ignored", {23'd0, tx_start_a, tx_data_a}, 32'h0A5);
    wait_done(1'b0, 8000);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("done_start_ignored_0", {31'd0, busy_a}, 32'd0);
    repeat (3) step();
    check("done_start_ignored_3", {31'd0, busy_a}, 32'd0);
    check_full_dump_a("ignored_dump", b0);
    check("ignored_done_count", done_cnt_a - d0, 1);
    check("mem_write_never_a", {31'd0, wr_seen_a}, 32'd0);
    check("mem_addr_bound_a", {31'd0, addr_over_a}, 32'd0);

    // Reset right after byte 37 (0-based) is sent, then replay from 0.
    b0 = bytes_a.size();
    d0 = done_cnt_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_bytes_a(b0 + 38, 1000);
    rst_n = 1'b0;
    #1;
    check("midreset_outs", {9'd0, busy_a, done_a, tx_start_a, mem_write_a, tx_data_a, mem_addr_a}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (12) step();
    check("midreset_no_done", done_cnt_a - d0, 0);
    check("midreset_idle", {30'd0, busy_a, tx_start_a}, 32'd0);
    check("midreset_no_bytes", bytes_a.size() - b0, 38);
    b1 = bytes_a.size();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_bytes_a(b1 + 2, 100);
    check("replay_byte0", {24'd0, bytes_a[b1]}, 32'hA5);
    check("replay_byte1", {24'd0, bytes_a[b1+1]}, 32'h00);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // 32-bit, 4-word instance: two back-to-back dumps.
    b0 = bytes_b.size();
    d0 = done_cnt_b;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    wait_done(1'b1, 200);
    step();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("b_restart_busy", {31'd0, busy_b}, 32'd1);
    wait_done(1'b1, 200);
    repeat (2) step();
    check("b_byte_count", bytes_b.size() - b0, 32);
    for (int i = 0; i < 32 && (b0 + i) < bytes_b.size(); i++)
      check("b_byte", {24'd0, bytes_b[b0+i]}, {24'd0, exp_b[i % 16]});
    check("b_done_count", done_cnt_b - d0, 2);
    check("b_addr_write_ok", {31'd0, addr_over_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_dumper.md
# data_memory_dumper

Read-side master for the data memory: on a start request it walks the data memory from address 0 to DUMP_DEPTH-1 and streams every word, most-significant byte first, to the UART transmitter. It sits between the data memory's read port and the debug UART TX, and drives the memory's address and write lines while the processor is halted.

## Interface

- RAM_WIDTH, 16: data memory word width; must be a multiple of 8.
- RAM_ADDR_BITS, 11: data memory address width.
- DUMP_DEPTH, 128: number of words dumped; 1 ≤ DUMP_DEPTH ≤ 2^RAM_ADDR_BITS.

- clk  in  1  single clock, rising edge; data memory shares it.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  dump request, sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse after the last byte's tx_done.
- mem_addr  out  RAM_ADDR_BITS  registered address to the data memory.
- mem_write  out  1  write strobe to the data memory; constant 0.
- mem_rdata  in  RAM_WIDTH  data memory registered read output (1-cycle latency).
- tx_data  out  8  byte to the UART TX, stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse requesting a byte transmission.
- tx_done  in  1  UART TX completion pulse for the current byte.

## Operation

- States: IDLE, READ, CAPTURE, SEND, WAIT_TX, DONE.
- IDLE: start=1 -> mem_addr<=0, byte_idx<=0 -> READ.
- READ: mem_addr is held. The memory samples it on this edge -> CAPTURE.
- CAPTURE: mem_rdata is valid. Latch it into word_reg; tx_data<=word_reg byte [RAM_WIDTH-1 -: 8] -> SEND.
- SEND: tx_start=1 for exactly this cycle -> WAIT_TX.
- WAIT_TX: wait for tx_done.
  - On tx_done with byte_idx < RAM_WIDTH/8-1: byte_idx++, tx_data<=next lower byte -> SEND.
  - On tx_done at the last byte with mem_addr < DUMP_DEPTH-1: mem_addr++, byte_idx<=0 -> READ.
  - On tx_done at the last byte with mem_addr == DUMP_DEPTH-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Byte order: ascending word address; within a word, MSB byte first. For the default widths, 2×DUMP_DEPTH = 256 bytes are sent.
- mem_addr never exceeds DUMP_DEPTH-1 and does not wrap. It holds its last value in IDLE.
- start while busy is ignored. A start in the same cycle as DONE is ignored; it is accepted from IDLE on the next cycle.
- tx_done outside WAIT_TX (including during SEND) is ignored. tx_done during WAIT_TX advances exactly once per byte.
- mem_write is 0 in all states, including during reset.

## Timing

- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, busy=0, done=0, tx_start=0;
  - tx_data=0, mem_addr=0, mem_write=0;
  - internal word_reg and byte_idx cleared.
- Reset mid-dump aborts immediately, with no done pulse. After release, the block waits for a new start.
- With edge E0 sampling start:
  - READ occupies the cycle after E0, with busy=1 from E0;
  - CAPTURE follows;
  - the first tx_start is high in the third cycle after E0.
- Between bytes of the same word: tx_start is high in the cycle after the tx_done edge.
- Between words: tx_start is high three cycles after the tx_done edge (READ, CAPTURE, SEND).
- done is high in the cycle after the final tx_done edge. busy falls together with the return to IDLE one cycle later.
- The block exerts no backpressure on tx_done. The TX is assumed to complete every accepted byte.

## Test plan

- Reset: hold rst_n=0 with start=1 and random tx_done. Required: all outputs 0 and no tx_start. Release rst_n: state stays IDLE until start.
- Full dump (defaults): preload word k with 16'hA500+k, TX model asserts tx_done 10 cycles after each tx_start. Required: 256 bytes A5,00,A5,01,…,A5,7F; one done pulse; mem_write never 1; mem_addr never above 127.
- Latency: start at E0 with the TX model replying tx_done in 1 cycle. Required:
  - tx_start at E0+3;
  - the second byte's tx_start one cycle after the first tx_done;
  - the next word's tx_start three cycles after the second tx_done.
- Ignored events: pulse start during WAIT_TX, and pulse tx_done during SEND and during IDLE. Required: byte sequence and count unchanged; exactly one done.
- Reset mid-dump: assert rst_n=0 after byte 37 is sent. Required: immediate IDLE with no done. Then a new start replays from address 0, byte A5,00.
- Parameter DUMP_DEPTH=4, RAM_WIDTH=32: words 32'h01020304+k·0x10. Required: 16 bytes, MSB first; done, then an immediate second start produces an identical stream.
